// File: rtl/button_event_detector.sv
// Turns a debounced button level into press, release, long-press and auto-repeat pulses.
// Latency: every pulse appears one clock after the enabled edge that caused it; pulses last one clock.
// Optional feature: define BUTTON_EVENT_AUTOREPEAT_EN to enable the repeat_o pulse train.
module button_event_detector #(
  parameter int   LONG_PRESS_TICKS = 1000,
  parameter int   REPEAT_TICKS     = 250,
  parameter logic ACTIVE_LEVEL     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic data_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o
);

  // Counter is sized for the larger of the two intervals, so it never wraps.
  localparam int MAX_TICKS = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LONG = CW'(LONG_PRESS_TICKS);
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam logic [CW-1:0] CNT_REP  = CW'(REPEAT_TICKS);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          act;
  logic          press_nxt, release_nxt, long_nxt, repeat_nxt;

  assign act = (data_i == ACTIVE_LEVEL);

  // Next-state, counter and pulse decode; nothing advances on edges without enable.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (act) begin
            state_nxt = HELD;
            cnt_nxt   = CNT_ONE;
            press_nxt = 1'b1;
          end
        end
        HELD: begin
          // Release wins over a threshold reached on the same edge.
          if (!act) begin
            state_nxt   = IDLE;
            cnt_nxt     = CNT_ZERO;
            release_nxt = 1'b1;
          end else if (cnt == CNT_LONG) begin
            state_nxt = LONG;
            cnt_nxt   = CNT_ONE;
            long_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        LONG: begin
          if (!act) begin
            state_nxt   = IDLE;
            cnt_nxt     = CNT_ZERO;
            release_nxt = 1'b1;
          end else begin
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
            if (cnt == CNT_REP) begin
              cnt_nxt    = CNT_ONE;
              repeat_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
`else
            // Without auto-repeat the counter parks at 1 until release.
            cnt_nxt = CNT_ONE;
`endif
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and registered outputs; pulses self-clear on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= CNT_ZERO;
      pressed_o    <= 1'b0;
      press_o      <= 1'b0;
      release_o    <= 1'b0;
      long_press_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pressed_o    <= (state_nxt != IDLE);
      press_o      <= press_nxt;
      release_o    <= release_nxt;
      long_press_o <= long_nxt;
    end
  end

`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  // Repeat pulse register, present only when auto-repeat is built in.
  always_ff @(posedge clock) begin
    if (reset) begin
      repeat_o <= 1'b0;
    end else begin
      repeat_o <= repeat_nxt;
    end
  end
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_detector.sv
// Self-checking bench for button_event_detector with LONG_PRESS_TICKS=4, REPEAT_TICKS=2.
// Reference model tracks how many consecutive enabled samples the button has been active.
// Directed scenarios first, then a long randomized run.
module tb_button_event_detector;

  localparam int LPT = 4;
  localparam int RPT = 2;

  logic clock;
  logic reset;
  logic enable;
  logic data_i;
  logic pressed_o;
  logic press_o;
  logic release_o;
  logic long_press_o;
  logic repeat_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state: consecutive active enabled samples (0 = released).
  int   hold_len  = 0;
  logic exp_pressed, exp_press, exp_release, exp_long, exp_repeat;
  // Last event seen on the DUT outputs: 0 none, 1 press, 2 release.
  int   last_evt  = 0;

  button_event_detector #(
    .LONG_PRESS_TICKS(LPT),
    .REPEAT_TICKS    (RPT),
    .ACTIVE_LEVEL    (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .data_i      (data_i),
    .pressed_o   (pressed_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .long_press_o(long_press_o),
    .repeat_o    (repeat_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pressed"}, pressed_o,    exp_pressed);
    check({tag, ".press"},   press_o,      exp_press);
    check({tag, ".release"}, release_o,    exp_release);
    check({tag, ".long"},    long_press_o, exp_long);
    check({tag, ".repeat"},  repeat_o,     exp_repeat);
    if (press_o === 1'b1) begin
      check({tag, ".alt_press"}, (last_evt == 1), 1'b0);
      last_evt = 1;
    end
    if (release_o === 1'b1) begin
      check({tag, ".alt_release"}, (last_evt == 2), 1'b0);
      last_evt = 2;
    end
  endtask

  // One clock with the given inputs; model updated from the rules, then outputs compared.
  task automatic step(input string tag, input logic en, input logic d);
    enable = en;
    data_i = d;
    @(posedge clock);
    #1;
    exp_press   = 1'b0;
    exp_release = 1'b0;
    exp_long    = 1'b0;
    exp_repeat  = 1'b0;
    if (en) begin
      if (d == 1'b1) begin
        hold_len++;
        exp_press = (hold_len == 1);
        exp_long  = (hold_len == LPT + 1);
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        exp_repeat = (hold_len > LPT + 1) && (((hold_len - (LPT + 1)) % RPT) == 0);
`endif
      end else begin
        exp_release = (hold_len > 0);
        hold_len    = 0;
      end
    end
    exp_pressed = (hold_len > 0);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles, input logic d);
    reset  = 1'b1;
    enable = 1'b1;
    data_i = d;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      hold_len    = 0;
      exp_pressed = 1'b0;
      exp_press   = 1'b0;
      exp_release = 1'b0;
      exp_long    = 1'b0;
      exp_repeat  = 1'b0;
      check_all(tag);
    end
    reset    = 1'b0;
    last_evt = 0;
  endtask

  initial begin
    logic cur_d;
    reset  = 1'b1;
    enable = 1'b0;
    data_i = 1'b0;

    // 1: short press and release
    do_reset("t1_reset", 3, 1'b0);
    step("t1_idle", 1'b1, 1'b0);
    step("t1_p1",   1'b1, 1'b1);
    step("t1_p2",   1'b1, 1'b1);
    step("t1_rel",  1'b1, 1'b0);
    step("t1_idle2",1'b1, 1'b0);

    // 2: long hold through long-press and repeats
    for (int i = 0; i < 10; i++) step("t2_hold", 1'b1, 1'b1);
    step("t2_rel", 1'b1, 1'b0);

    // 3: release exactly on the threshold edge
    for (int i = 0; i < LPT; i++) step("t3_hold", 1'b1, 1'b1);
    step("t3_rel", 1'b1, 1'b0);
    step("t3_idle", 1'b1, 1'b0);

    // 4: enable toggling with data held
    for (int i = 0; i < 12; i++) begin
      step("t4_en",  1'b1, 1'b1);
      step("t4_dis", 1'b0, 1'b1);
    end
    step("t4_dis_drop", 1'b0, 1'b0);
    step("t4_rel", 1'b1, 1'b0);

    // 5: reset mid-LONG with data still active
    for (int i = 0; i < 8; i++) step("t5_hold", 1'b1, 1'b1);
    do_reset("t5_reset", 2, 1'b1);
    step("t5_dis",   1'b0, 1'b1);
    step("t5_press", 1'b1, 1'b1);
    step("t5_hold2", 1'b1, 1'b1);
    step("t5_rel",   1'b1, 1'b0);

    // 6: randomized level with sticky changes so long holds occur
    cur_d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) cur_d = ~cur_d;
      step("t6_rand", ($urandom_range(0, 3) != 0), cur_d);
    end
    step("t6_end", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
